// File: rtl/rule_match_unpacker_if.sv
`default_nettype none
// =============================================================================
// rule_match_unpacker_if : packed rule-match input, metadata and rule output
//                          handshake bundle for rule_match_unpacker.
// Revision: 1.0
// =============================================================================

package rule_match_unpacker_pkg;
   typedef logic [63:0] metadata_t;
endpackage

interface rule_match_unpacker_if;
   import rule_match_unpacker_pkg::*;

   logic             in_match_valid;
   logic [511:0]     in_match_data;
   logic             in_match_sop;
   logic             in_match_eop;
   logic [5:0]       in_match_empty;
   logic             in_match_ready;

   logic             in_meta_valid;
   metadata_t        in_meta_data;
   logic             in_meta_ready;

   logic             out_rule_valid;
   logic [15:0]      out_rule_data;
   logic             out_rule_sop;
   logic             out_rule_eop;
   logic             out_rule_ready;

   logic             out_meta_valid;
   metadata_t        out_meta_data;
   logic             out_meta_ready;

   modport slave (
      input  in_match_valid, in_match_data, in_match_sop, in_match_eop, in_match_empty,
      output in_match_ready,
      input  in_meta_valid, in_meta_data,
      output in_meta_ready,
      output out_rule_valid, out_rule_data, out_rule_sop, out_rule_eop,
      input  out_rule_ready,
      output out_meta_valid, out_meta_data,
      input  out_meta_ready
   );

   modport master (
      output in_match_valid, in_match_data, in_match_sop, in_match_eop, in_match_empty,
      input  in_match_ready,
      output in_meta_valid, in_meta_data,
      input  in_meta_ready,
      input  out_rule_valid, out_rule_data, out_rule_sop, out_rule_eop,
      output out_rule_ready,
      input  out_meta_valid, out_meta_data,
      output out_meta_ready
   );
endinterface

`default_nettype wire

// File: rtl/rule_match_unpacker.sv
`default_nettype none
// =============================================================================
// rule_match_unpacker : turns 512-bit packed rule-match beats into one rule ID
//                       per cycle, ending each packet with a zero terminator.
// Revision: 1.0
// =============================================================================

module rule_match_unpacker
   import rule_match_unpacker_pkg::*;
#(
   parameter int RULE_AWIDTH = 13,
   parameter int NUM_LANES   = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   rule_match_unpacker_if.slave  bus,
   output logic [31:0]           rule_cnt,
   output logic [31:0]           pkt_cnt
);

   localparam int IDX_W = $clog2(NUM_LANES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SCAN = 3'd2,
      TERM = 3'd3,
      META = 3'd4
   } state_t;

   state_t                  state;
   state_t                  next_state;

   logic [RULE_AWIDTH-1:0]  lane_val  [NUM_LANES];
   logic [NUM_LANES-1:0]    lane_nz;
   logic [RULE_AWIDTH-1:0]  lane_rule [NUM_LANES];
   logic [NUM_LANES-1:0]    lane_mask;
   logic                    last_beat;
   logic                    first_flag;
   metadata_t               meta_q;
   logic [IDX_W-1:0]        sel_idx;

   logic                    meta_ready_c;
   logic                    match_ready_c;
   logic                    rule_valid_c;
   logic [15:0]             rule_data_c;
   logic                    rule_sop_c;
   logic                    rule_eop_c;
   logic                    meta_valid_c;
   logic                    meta_take;
   logic                    beat_take;
   logic                    rule_take;
   logic                    term_take;
   logic                    meta_done;

   logic                    unused_inputs;
   assign unused_inputs = ^{bus.in_match_sop, bus.in_match_empty, bus.in_match_data};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_val[i] = bus.in_match_data[16*i +: RULE_AWIDTH];
      assign lane_nz[i]  = |lane_val[i];
   end

   always_comb begin
      sel_idx = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (lane_mask[i]) sel_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state    = state;
      meta_ready_c  = 1'b0;
      match_ready_c = 1'b0;
      rule_valid_c  = 1'b0;
      rule_data_c   = '0;
      rule_sop_c    = 1'b0;
      rule_eop_c    = 1'b0;
      meta_valid_c  = 1'b0;
      meta_take     = 1'b0;
      beat_take     = 1'b0;
      rule_take     = 1'b0;
      term_take     = 1'b0;
      meta_done     = 1'b0;
      case (state)
         IDLE: begin
            meta_ready_c = 1'b1;
            if (bus.in_meta_valid) begin
               meta_take  = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            match_ready_c = 1'b1;
            if (bus.in_match_valid) begin
               beat_take  = 1'b1;
               next_state = SCAN;
            end
         end
         SCAN: begin
            if (lane_mask != '0) begin
               rule_valid_c = 1'b1;
               rule_data_c  = 16'(lane_rule[sel_idx]);
               rule_sop_c   = first_flag;
               rule_take    = bus.out_rule_ready;
            end else begin
               next_state = last_beat ? TERM : LOAD;
            end
         end
         TERM: begin
            rule_valid_c = 1'b1;
            rule_eop_c   = 1'b1;
            rule_sop_c   = first_flag;
            if (bus.out_rule_ready) begin
               term_take  = 1'b1;
               next_state = META;
            end
         end
         META: begin
            meta_valid_c = 1'b1;
            if (bus.out_meta_ready) begin
               meta_done  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The reset state is IDLE, so metadata ready must be masked while reset is held.
   assign bus.in_meta_ready  = meta_ready_c & rst_n;
   assign bus.in_match_ready = match_ready_c;
   assign bus.out_rule_valid = rule_valid_c;
   assign bus.out_rule_data  = rule_data_c;
   assign bus.out_rule_sop   = rule_sop_c;
   assign bus.out_rule_eop   = rule_eop_c;
   assign bus.out_meta_valid = meta_valid_c;
   assign bus.out_meta_data  = meta_q;

   always_ff @(posedge clk) begin
      if (beat_take) lane_rule <= lane_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_mask  <= '0;
         last_beat  <= 1'b0;
         first_flag <= 1'b0;
         meta_q     <= '0;
         rule_cnt   <= '0;
         pkt_cnt    <= '0;
      end else begin
         if (meta_take) begin
            meta_q     <= bus.in_meta_data;
            first_flag <= 1'b1;
         end
         if (beat_take) begin
            lane_mask <= lane_nz;
            last_beat <= bus.in_match_eop;
         end
         // Clearing the lowest set bit retires exactly the lane being emitted.
         if (rule_take) begin
            lane_mask  <= lane_mask & (lane_mask - 1'b1);
            first_flag <= 1'b0;
            rule_cnt   <= rule_cnt + 32'd1;
         end
         if (term_take) first_flag <= 1'b0;
         if (meta_done) pkt_cnt <= pkt_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire
